// File: rtl/mul64_iter.sv
// mul64_iter: iterative RV64M multiplier (MUL / MULH / MULHSU / MULHU).
// Operands are reduced to unsigned magnitudes. A 64-step shift-add loop
// then builds the 128-bit product through a single shared add64 instance.
// The product is conditionally negated in two 64-bit halves, and the
// selected half is returned over a valid/ready handshake.
// Optional build macro: MUL64_EARLY_OUT_EN. When it is defined, the shift-add
// loop terminates as soon as the remaining multiplier bits are all zero.

// add64: 64-bit carry-lookahead adder built from 4-bit lookahead groups.
module add64 (
  input  logic [63:0] operand1,
  input  logic [63:0] operand2,
  input  logic        c0,
  output logic [63:0] result,
  output logic        carry
);
  logic [63:0] g;
  logic [63:0] p;
  logic [64:0] c;

  assign g    = operand1 & operand2;
  assign p    = operand1 ^ operand2;
  assign c[0] = c0;

  for (genvar k = 0; k < 16; k++) begin : g_grp
    localparam int B = 4 * k;
    assign c[B+1] = g[B] | (p[B] & c[B]);
    assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & c[B]);
    assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                  | (p[B+2] & p[B+1] & p[B] & c[B]);
    assign c[B+4] = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                  | (p[B+3] & p[B+2] & p[B+1] & g[B])
                  | (p[B+3] & p[B+2] & p[B+1] & p[B] & c[B]);
  end

  assign result = p ^ c[63:0];
  assign carry  = c[64];
endmodule

module mul64_iter #(
  parameter int XLEN = 64,
  parameter int OP_W = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OP_W-1:0] op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  typedef enum logic [2:0] {IDLE, CALC, NEG_LO, NEG_HI, DONE} state_t;

  localparam logic [OP_W-1:0] OP_MUL    = 2'd0;
  localparam logic [OP_W-1:0] OP_MULH   = 2'd1;
  localparam logic [OP_W-1:0] OP_MULHSU = 2'd2;

  state_t            state, state_nx;
  logic [OP_W-1:0]   op_q;
  logic [XLEN-1:0]   mcand;
  logic [XLEN-1:0]   acc_hi;
  logic [XLEN-1:0]   prod_lo;
  logic [5:0]        cnt;
  logic              neg;
  logic              neg_carry;

  logic              accept;
  logic              sa, sb;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [XLEN-1:0]   add_op1, add_op2, add_sum;
  logic              add_c0, add_carry;
  logic              early_out;

  // Sign handling: only the high-half ops treat operands as signed.
  assign accept = in_valid & in_ready;
  assign sa     = a[XLEN-1] & ((op == OP_MULH) | (op == OP_MULHSU));
  assign sb     = b[XLEN-1] & (op == OP_MULH);
  assign a_mag  = sa ? -a : a;
  assign b_mag  = sb ? -b : b;

`ifdef MUL64_EARLY_OUT_EN
  // After cnt steps the unconsumed multiplier bits sit in prod_lo[63-cnt:0].
  logic [XLEN-1:0]   live_mask;
  logic [6:0]        rem_shift;
  logic [2*XLEN-1:0] shifted;
  assign live_mask = {XLEN{1'b1}} >> cnt;
  assign early_out = ((prod_lo & live_mask) == '0);
  assign rem_shift = 7'd64 - {1'b0, cnt};
  assign shifted   = {acc_hi, prod_lo} >> rem_shift;
`else
  assign early_out = 1'b0;
`endif

  add64 u_add (
    .operand1 (add_op1),
    .operand2 (add_op2),
    .c0       (add_c0),
    .result   (add_sum),
    .carry    (add_carry)
  );

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_nx unassigned,
    // which would otherwise infer a latch.
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = CALC;
      CALC:    if (early_out || cnt == 6'd63) state_nx = NEG_LO;
      NEG_LO:  state_nx = NEG_HI;
      NEG_HI:  state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs and adder operand selection for the current state.
  always_comb begin
    in_ready = (state == IDLE) & ~rst;
    busy     = (state != IDLE);
    add_op1  = acc_hi;
    add_op2  = mcand & {XLEN{prod_lo[0]}};
    add_c0   = 1'b0;
    case (state)
      NEG_LO: begin
        add_op1 = ~prod_lo;
        add_op2 = '0;
        add_c0  = 1'b1;
      end
      NEG_HI: begin
        add_op1 = ~acc_hi;
        add_op2 = '0;
        add_c0  = neg_carry;
      end
      default: ;
    endcase
  end

  // Datapath: operand latch, shift-add steps, two-half negation, result hold.
  always_ff @(posedge clk) begin
    // NOTE: every datapath register is cleared on reset, so an aborted
    // operation can never leak a partial product into a later result.
    if (rst) begin
      op_q      <= '0;
      mcand     <= '0;
      acc_hi    <= '0;
      prod_lo   <= '0;
      cnt       <= '0;
      neg       <= 1'b0;
      neg_carry <= 1'b0;
      result    <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q    <= op;
            mcand   <= a_mag;
            prod_lo <= b_mag;
            acc_hi  <= '0;
            cnt     <= '0;
            neg     <= sa ^ sb;
          end
        end
        CALC: begin
`ifdef MUL64_EARLY_OUT_EN
          if (early_out) {acc_hi, prod_lo} <= shifted;
          else
`endif
          begin
            acc_hi  <= {add_carry, add_sum[XLEN-1:1]};
            prod_lo <= {add_sum[0], prod_lo[XLEN-1:1]};
          end
          cnt <= cnt + 6'd1;
        end
        NEG_LO: begin
          if (neg) begin
            prod_lo   <= add_sum;
            neg_carry <= add_carry;
          end else begin
            neg_carry <= 1'b0;
          end
        end
        NEG_HI: begin
          if (neg) acc_hi <= add_sum;
          result    <= (op_q == OP_MUL) ? prod_lo : (neg ? add_sum : acc_hi);
          out_valid <= 1'b1;
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul64_iter.sv
// tb_mul64_iter: directed-vector bench for mul64_iter.
// Checks results, latency, backpressure and mid-operation reset. When built
// with MUL64_EARLY_OUT_EN it expects the shortened latencies.
module tb_mul64_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic [63:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;
  logic        busy;

  int n_vec  = 0;
  int n_fail = 0;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    int          lat_eo;
  } vec_t;

  vec_t vecs[$];

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MSB  = 64'h8000_0000_0000_0000;

  mul64_iter dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  task automatic add_vec(input string name, input logic [1:0] vop, input logic [63:0] va,
                         input logic [63:0] vb, input logic [63:0] vexp, input int lat_eo);
    vec_t v;
    v.name = name; v.op = vop; v.a = va; v.b = vb; v.exp = vexp; v.lat_eo = lat_eo;
    vecs.push_back(v);
  endtask

  // Issue one request, wait for the result, check latency/result, optionally
  // hold backpressure for 10 cycles, then release.
  task automatic run_vec(input vec_t v, input bit hold);
    int          lat;
    int          exp_lat;
    logic [63:0] held;
`ifdef MUL64_EARLY_OUT_EN
    exp_lat = v.lat_eo;
`else
    exp_lat = 67;
`endif
    in_valid = 1'b1; op = v.op; a = v.a; b = v.b;
    @(posedge clk); #1;
    in_valid = 1'b0; op = ~v.op; a = ~v.a; b = ~v.b;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check({v.name, "_lat"}, 64'(lat + 1), 64'(exp_lat));
    check({v.name, "_res"}, result, v.exp);
    if (hold) begin
      held = result;
      for (int i = 0; i < 10; i++) begin
        in_valid = (i == 3);
        @(posedge clk); #1;
        check("bp_result", result, held);
        check("bp_out_valid", {63'b0, out_valid}, 64'd1);
        check("bp_in_ready", {63'b0, in_ready}, 64'd0);
        check("bp_busy", {63'b0, busy}, 64'd1);
      end
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    if (hold) begin
      check("rel_out_valid", {63'b0, out_valid}, 64'd0);
      check("rel_in_ready", {63'b0, in_ready}, 64'd1);
      @(posedge clk); #1;
      check("rel_no_accept_busy", {63'b0, busy}, 64'd0);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;

    // Vector table: name, op, a, b, expected, early-out latency.
    add_vec("mulhu_ff_ff",  2'd3, ONES, ONES, 64'hFFFF_FFFF_FFFF_FFFE, 67);
    add_vec("mul_ff_ff",    2'd0, ONES, ONES, 64'h1, 67);
    add_vec("mulh_min_min", 2'd1, MSB, MSB, 64'h4000_0000_0000_0000, 67);
    add_vec("mulh_m1_1",    2'd1, ONES, 64'd1, ONES, 5);
    add_vec("mulh_0_min",   2'd1, 64'd0, MSB, 64'd0, 67);
    add_vec("mulhsu_m1_2",  2'd2, ONES, 64'd2, ONES, 6);
    add_vec("mul_m1_2",     2'd0, ONES, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 6);
    add_vec("mulhu_m1_2",   2'd3, ONES, 64'd2, 64'd1, 6);
    add_vec("mul_m3_5",     2'd0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 64'hFFFF_FFFF_FFFF_FFF1, 7);
    add_vec("mulh_m3_5",    2'd1, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, ONES, 7);
    add_vec("mulh_m3_m5",   2'd1, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 7);
    add_vec("mulhu_x_0",    2'd3, 64'h1234_5678_9ABC_DEF0, 64'd0, 64'd0, 4);
    add_vec("mul_7_1",      2'd0, 64'd7, 64'd1, 64'd7, 5);
    add_vec("mulhu_x_min",  2'd3, 64'h123, MSB, 64'h91, 67);

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", {63'b0, in_ready}, 64'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", {63'b0, in_ready}, 64'd1);
    check("post_rst_out_valid", {63'b0, out_valid}, 64'd0);
    check("post_rst_busy", {63'b0, busy}, 64'd0);
    check("post_rst_result", result, 64'd0);
    @(posedge clk); #1;

    foreach (vecs[i]) run_vec(vecs[i], 1'b0);

    // Backpressure on the first vector's operands.
    run_vec(vecs[0], 1'b1);

    // Abort mid-CALC with a one-cycle reset, then a clean operation.
    in_valid = 1'b1; op = 2'd0; a = ONES; b = ONES;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (29) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("abort_in_ready", {63'b0, in_ready}, 64'd1);
    check("abort_out_valid", {63'b0, out_valid}, 64'd0);
    check("abort_busy", {63'b0, busy}, 64'd0);
    begin
      vec_t v;
      v.name = "mul_3_5_after_abort"; v.op = 2'd0; v.a = 64'd3; v.b = 64'd5;
      v.exp = 64'd15; v.lat_eo = 7;
      run_vec(v, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
